// File: rtl/dl_reset_seq_pkg.sv
// Shared types and helpers for the ABC80 download tracker / reset sequencer.
// Provides the sequencer state enum, counter width helper and slot-mask test.
package abc80_dl_pkg;

    typedef enum logic [1:0] {
        WAIT,
        DL,
        HOLD,
        RUN
    } state_t;

    localparam int IDX_W = 8;

    // Width of a down-counter that must hold n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when idx names a tracked slot and that slot's mask bit is set.
    function automatic logic in_mask(
        input logic [255:0]     mask,
        input logic [IDX_W-1:0] idx,
        input int               n
    );
        return (int'(idx) < n) && mask[idx];
    endfunction

endpackage

// File: rtl/dl_reset_seq_if.sv
// data_io download bus: download flag, slot index, write strobe, address.
// master drives the bus (data_io side), slave observes it (sequencer side).
interface dl_reset_seq_if #(
    parameter int ADDR_W = 25
);
    import abc80_dl_pkg::*;

    logic              ioctl_download;
    logic [IDX_W-1:0]  ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr
    );

    modport slave (
        input ioctl_download,
        input ioctl_index,
        input ioctl_wr,
        input ioctl_addr
    );
endinterface

// File: rtl/dl_reset_seq_tracker.sv
// Download tracker: edge detect, per-download length/write tracking, loaded flags.
// Ports: clk/rst, bus (slave), rise/fall strobes, index, next loaded, status outs.
module dl_tracker
    import abc80_dl_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int ADDR_W  = 25
) (
    input  logic               clk_sys,
    input  logic               reset,
    dl_reset_seq_if.slave      bus,
    output logic               rise_o,
    output logic               fall_o,
    output logic [IDX_W-1:0]   cur_idx_o,
    output logic [N_SLOTS-1:0] loaded_nx_o,
    output logic [N_SLOTS-1:0] loaded_o,
    output logic               dl_done_o,
    output logic               dl_err_o,
    output logic [ADDR_W:0]    dl_len_o
);

    logic               dl_q;
    logic               skip_q, skip_d;
    logic               wrote_q, wrote_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]    len_q, len_d, wr_len;
    logic [N_SLOTS-1:0] loaded_q, loaded_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W:0]    dl_len_q, dl_len_d;
    logic               valid;

    // skip_q masks a download already running when reset released, so its
    // fall can never be mistaken for a completed load.
    always_comb begin
        rise_o   = bus.ioctl_download & ~dl_q & ~skip_q;
        fall_o   = ~bus.ioctl_download & dl_q & ~skip_q;
        skip_d   = skip_q & bus.ioctl_download;
        valid    = int'(idx_q) < N_SLOTS;
        idx_d    = rise_o ? bus.ioctl_index : idx_q;
        wr_len   = {1'b0, bus.ioctl_addr} + (ADDR_W+1)'(1);
        len_d    = rise_o ? '0 : len_q;
        wrote_d  = rise_o ? 1'b0 : wrote_q;
        if (bus.ioctl_download && bus.ioctl_wr) begin
            wrote_d = 1'b1;
            if (wr_len > len_d) len_d = wr_len;
        end
        loaded_d = loaded_q;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (fall_o && wrote_q && int'(idx_q) == i)
                loaded_d[i] = 1'b1;
        end
        done_d   = fall_o & valid;
        err_d    = fall_o & ~valid;
        dl_len_d = fall_o ? len_q : dl_len_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q     <= 1'b0;
            skip_q   <= 1'b1;
            wrote_q  <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
            loaded_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dl_len_q <= '0;
        end else begin
            dl_q     <= bus.ioctl_download;
            skip_q   <= skip_d;
            wrote_q  <= wrote_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dl_len_q <= dl_len_d;
        end
    end

    assign cur_idx_o   = idx_d;
    assign loaded_nx_o = loaded_d;
    assign loaded_o    = loaded_q;
    assign dl_done_o   = done_q;
    assign dl_err_o    = err_q;
    assign dl_len_o    = dl_len_q;

endmodule

// File: rtl/dl_reset_seq.sv
// Core reset sequencer: waits for required slots, stretches resets, holds on ROM loads.
// Ports: clk_sys/reset, rst_req, bus (slave), core_reset, loaded, dl_* status.
module dl_reset_seq
    import abc80_dl_pkg::*;
#(
    parameter int                 N_SLOTS     = 4,
    parameter logic [N_SLOTS-1:0] REQ_MASK    = N_SLOTS'(1),
    parameter logic [N_SLOTS-1:0] RESET_ON_DL = N_SLOTS'(1),
    parameter int                 HOLD_CYCLES = 1024,
    parameter int                 ADDR_W      = 25
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               rst_req,
    dl_reset_seq_if.slave      bus,
    output logic               core_reset,
    output logic [N_SLOTS-1:0] loaded,
    output logic               dl_done,
    output logic               dl_err,
    output logic [ADDR_W:0]    dl_len,
    output logic               dl_busy_rst
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               core_rst_q, busy_q;
    logic               rise, fall;
    logic [IDX_W-1:0]   cur_idx;
    logic [N_SLOTS-1:0] loaded_nx;

    function automatic logic req_ok(input logic [N_SLOTS-1:0] v);
        return (v & REQ_MASK) == REQ_MASK;
    endfunction

    dl_tracker #(
        .N_SLOTS (N_SLOTS),
        .ADDR_W  (ADDR_W)
    ) u_trk (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .bus         (bus),
        .rise_o      (rise),
        .fall_o      (fall),
        .cur_idx_o   (cur_idx),
        .loaded_nx_o (loaded_nx),
        .loaded_o    (loaded),
        .dl_done_o   (dl_done),
        .dl_err_o    (dl_err),
        .dl_len_o    (dl_len)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT: begin
                if (req_ok(loaded) && !bus.ioctl_download) begin
                    state_d = HOLD;
                    cnt_d   = CNT_LD;
                end
            end
            DL: begin
                // Judge the requirement on the flags this fall produces.
                if (fall) begin
                    if (req_ok(loaded_nx)) begin
                        state_d = HOLD;
                        cnt_d   = CNT_LD;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            HOLD: begin
                if (rst_req)
                    cnt_d = CNT_LD;
                else if (cnt_q == '0)
                    state_d = RUN;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            RUN: begin
                if (rst_req) begin
                    state_d = HOLD;
                    cnt_d   = CNT_LD;
                end
            end
            default: state_d = WAIT;
        endcase
        // A reset-class download start overrides everything, incl. rst_req.
        if (rise && in_mask(256'(RESET_ON_DL), cur_idx, N_SLOTS))
            state_d = DL;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT;
            cnt_q      <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            core_rst_q <= (state_d != RUN);
            busy_q     <= (state_d == DL);
        end
    end

    assign core_reset  = core_rst_q;
    assign dl_busy_rst = busy_q;

endmodule

// File: tb/tb_dl_reset_seq.sv
// Directed + randomized bench for dl_reset_seq against a slot/length model.
// Checks reset values, load tracking, pulses, stretch and release latency.
module tb_dl_reset_seq;

    localparam int H = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        rst_req;
    logic        core_reset;
    logic [3:0]  loaded;
    logic        dl_done;
    logic        dl_err;
    logic [25:0] dl_len;
    logic        dl_busy_rst;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] loaded_m;

    dl_reset_seq_if #(.ADDR_W(25)) bus ();

    dl_reset_seq dut (
        .clk_sys     (clk),
        .reset       (reset),
        .rst_req     (rst_req),
        .bus         (bus),
        .core_reset  (core_reset),
        .loaded      (loaded),
        .dl_done     (dl_done),
        .dl_err      (dl_err),
        .dl_len      (dl_len),
        .dl_busy_rst (dl_busy_rst)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one download; leaves ioctl_download low but unsampled.
    task automatic run_dl(input int idx, input int nwr, input int maxa,
                          input bit seq, input bit cr_exp,
                          output int exp_len);
        int a;
        int cr_bad;
        int busy_bad;
        cr_bad   = 0;
        busy_bad = 0;
        exp_len  = 0;
        bus.ioctl_index    = 8'(idx);
        bus.ioctl_download = 1'b1;
        tick;
        if (core_reset !== cr_exp) cr_bad++;
        if (dl_busy_rst !== (idx == 0)) busy_bad++;
        for (int w = 0; w < nwr; w++) begin
            if (seq) a = w;
            else if (w == nwr - 1) a = maxa;
            else a = int'($urandom_range(0, maxa));
            bus.ioctl_addr = 25'(a);
            bus.ioctl_wr   = 1'b1;
            tick;
            bus.ioctl_wr   = 1'b0;
            if (a + 1 > exp_len) exp_len = a + 1;
            if (core_reset !== cr_exp) cr_bad++;
            if (dl_busy_rst !== (idx == 0)) busy_bad++;
        end
        bus.ioctl_download = 1'b0;
        chk("core_reset_during_dl", cr_bad, 0);
        chk("busy_during_dl", busy_bad, 0);
    endtask

    // Samples the fall, checks the status pulse, then its clearing.
    task automatic end_dl(input int idx, input int nwr, input int exp_len);
        bit valid;
        valid = (idx < 4);
        if (valid && nwr > 0) loaded_m[idx] = 1'b1;
        tick;
        chk("dl_done_pulse", dl_done, valid);
        chk("dl_err_pulse", dl_err, !valid);
        chk("dl_len", dl_len, exp_len);
        chk("loaded", loaded, loaded_m);
        tick;
        chk("dl_done_clear", dl_done, 0);
        chk("dl_err_clear", dl_err, 0);
    endtask

    task automatic wait_release(input int start, input int exp,
                                input string tag);
        int cyc;
        cyc = start;
        while (core_reset !== 1'b0 && cyc < start + 3000) begin
            tick;
            cyc++;
        end
        chk(tag, cyc, exp);
    endtask

    initial begin
        int len;
        int nwr;
        int idx;
        int bad;
        int seen;

        reset              = 1'b1;
        rst_req            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = '0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        loaded_m           = '0;
        #1;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_loaded", loaded, 0);
        chk("rst_dl_done", dl_done, 0);
        chk("rst_dl_err", dl_err, 0);
        chk("rst_dl_len", dl_len, 0);
        chk("rst_busy", dl_busy_rst, 0);
        tick;
        tick;
        reset = 1'b0;

        // No downloads: core stays in reset.
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (core_reset !== 1'b1) bad++;
        end
        chk("idle_core_reset", bad, 0);
        chk("idle_loaded", loaded, loaded_m);

        // Invalid slot, then zero-write slot 0.
        run_dl(7, 10, 9, 1'b1, 1'b1, len);
        end_dl(7, 10, len);
        run_dl(0, 0, 0, 1'b0, 1'b1, len);
        end_dl(0, 0, len);
        chk("zero_wr_busy", dl_busy_rst, 0);
        repeat (20) tick;
        chk("zero_wr_core_reset", core_reset, 1);

        // ROM load: 16 KiB to slot 0.
        run_dl(0, 16384, 16383, 1'b1, 1'b1, len);
        end_dl(0, 16384, len);
        chk("rom_hold", core_reset, 1);
        wait_release(2, 1 + H, "rom_release_latency");

        // BAC load into slot 1 while running.
        nwr = int'($urandom_range(20, 60));
        run_dl(1, nwr, 299, 1'b0, 1'b0, len);
        end_dl(1, nwr, len);
        chk("bac_dl_len_300", dl_len, 300);
        chk("bac_core_reset", core_reset, 0);

        // rst_req pulse of 5 cycles.
        rst_req = 1'b1;
        tick;
        chk("rst_req_core_reset", core_reset, 1);
        chk("rst_req_busy", dl_busy_rst, 0);
        repeat (4) tick;
        rst_req = 1'b0;
        wait_release(0, H, "rst_req_stretch");

        // Randomized downloads while running.
        for (int k = 0; k < 8; k++) begin
            idx = int'($urandom_range(0, 9));
            nwr = int'($urandom_range(0, 20));
            run_dl(idx, nwr, int'($urandom_range(0, 5000)), 1'b0,
                   (idx == 0), len);
            end_dl(idx, nwr, len);
            if (idx == 0)
                wait_release(2, 1 + H, "rand_release_latency");
            else
                chk("rand_core_reset", core_reset, 0);
        end

        // rst_req and a ROM download start on the same edge.
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        rst_req            = 1'b1;
        tick;
        chk("tie_busy", dl_busy_rst, 1);
        chk("tie_core_reset", core_reset, 1);
        rst_req = 1'b0;
        repeat (3) tick;
        chk("tie_busy_hold", dl_busy_rst, 1);
        bus.ioctl_download = 1'b0;
        end_dl(0, 0, 0);
        wait_release(2, 1 + H, "tie_release_latency");

        // Asynchronous reset in the middle of a slot-0 download.
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        tick;
        bus.ioctl_wr = 1'b1;
        repeat (3) tick;
        #2;
        reset    = 1'b1;
        loaded_m = '0;
        #1;
        chk("mid_rst_core_reset", core_reset, 1);
        chk("mid_rst_loaded", loaded, loaded_m);
        chk("mid_rst_busy", dl_busy_rst, 0);
        tick;
        reset = 1'b0;
        repeat (5) tick;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        seen = 0;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (dl_done === 1'b1) seen++;
            if (core_reset !== 1'b1) bad++;
        end
        chk("mid_rst_no_done", seen, 0);
        chk("mid_rst_loaded_after", loaded, loaded_m);
        chk("mid_rst_held", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_reset_seq.md
# dl_reset_seq

Parametrised download tracker and core-reset sequencer for the ABC80 top level on Calypso, replacing the single `rom_loaded` flag and one-line reset OR. It watches the `data_io` download bus and tracks which download slots (`ioctl_index` values) have completed a non-empty load. It holds the core in reset until every required slot is loaded, then stretches each reset for a fixed cycle count. Per-slot policy decides whether a download forces the core into reset (ROM images) or runs while the core keeps executing (BAC program loads).

## Interface
- `N_SLOTS`, 4: number of tracked download indices, 0..N_SLOTS-1; must be ≥1.
- `REQ_MASK`, 4'b0001: slots that must be loaded before reset is first released.
- `RESET_ON_DL`, 4'b0001: slots whose download holds the core in reset for its whole duration.
- `HOLD_CYCLES`, 1024: reset stretch length in `clk_sys` cycles; must be ≥1.
- `ADDR_W`, 25: width of `ioctl_addr`.

- `clk_sys` in 1: system clock; the same clock as `data_io`.
- `reset` in 1: asynchronous, active-high global reset.
- `rst_req` in 1: synchronous reset request, e.g. OSD reset bit OR reset button; level-sensitive.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: slot of the current download; stable while `ioctl_download` is high.
- `ioctl_wr` in 1: byte write strobe.
- `ioctl_addr` in ADDR_W: address of the byte being written.
- `core_reset` out 1: reset to the machine core, active-high.
- `loaded` out N_SLOTS: per-slot "loaded at least once" flags.
- `dl_done` out 1: one-cycle pulse when a valid-slot download ends.
- `dl_err` out 1: one-cycle pulse when a download with index ≥ N_SLOTS ends.
- `dl_len` out ADDR_W+1: byte length of the last download that ended (valid or invalid).
- `dl_busy_rst` out 1: a reset-class download is currently in progress.

## Operation
- Edge detection: `dl_q` registers `ioctl_download`.
  - rise = `ioctl_download & ~dl_q`; fall = `~ioctl_download & dl_q`.
  - On rise, latch `ioctl_index` into `cur_idx`, clear `len_acc` and clear `wrote`.
- Length tracking:
  - On each `ioctl_wr` while downloading, set `wrote`.
  - Set `len_acc = max(len_acc, ioctl_addr+1)`, computed at ADDR_W+1 bits with no wrap.
- On fall:
  - `dl_len <= len_acc`.
  - If `cur_idx < N_SLOTS`: pulse `dl_done`; if `wrote`, set `loaded[cur_idx]`.
  - Otherwise: pulse `dl_err` and leave `loaded` unchanged.
  - A zero-write download never sets `loaded`.
- `loaded` bits clear only on `reset`.
- FSM states: WAIT, DL, HOLD, RUN. `core_reset` is 1 in WAIT, DL and HOLD, and 0 only in RUN.
  - Any state, on rise with `cur_idx` in `RESET_ON_DL` → DL. Indices ≥ N_SLOTS never enter DL.
  - WAIT: when `(loaded & REQ_MASK) == REQ_MASK` and `ioctl_download` is low → HOLD, with `cnt = HOLD_CYCLES-1`.
  - DL: on fall → HOLD if the requirement is met using the updated `loaded`, else → WAIT.
  - HOLD: `cnt` decrements each cycle. `rst_req` reloads `cnt = HOLD_CYCLES-1`. When `cnt == 0` and `rst_req` is low → RUN.
  - RUN: `rst_req` → HOLD (reload). A non-reset-class download leaves RUN unchanged.
- `dl_busy_rst` is 1 exactly while in DL.
- Simultaneous `rst_req` and reset-class rise: DL wins.

## Timing
- Reset values: `core_reset` = 1, `loaded` = 0, `dl_done` = 0, `dl_err` = 0, `dl_len` = 0, `dl_busy_rst` = 0; state WAIT; `dl_q` = 0; `cnt` = 0.
- On an asynchronous `reset` mid-download, the sequencer ignores that download's fall; it does not set `loaded` and does not pulse `dl_done`.
- All outputs are registered.
- `dl_done`, `dl_err`, `dl_len` and the `loaded` update appear on the clock edge that samples the fall; they are visible the cycle after `ioctl_download` is first seen low.
- The DL entry appears on the edge that samples the rise: `core_reset` is already 1 in the first cycle `ioctl_download` is seen high.
- Reset stretch: `core_reset` stays 1 for exactly HOLD_CYCLES cycles in HOLD after the last `rst_req` cycle, or after entering HOLD.
- Release latency from fall of the last required download: 1 + HOLD_CYCLES cycles.

## Structure
- Package `abc80_dl_pkg`:
  - `state_t` enum {WAIT, DL, HOLD, RUN}.
  - `clog2`-based width localparam for `cnt`.
  - Function `in_mask(mask, idx)`, bounds-checked against N_SLOTS.
- Sub-module `dl_tracker`: owns edge detection, `cur_idx`, `len_acc`, `wrote`, and the `loaded`, `dl_done`, `dl_err` and `dl_len` outputs. It exports rise and fall strobes plus `cur_idx` to the FSM in `dl_reset_seq`.

## Test plan
- Default parameters, `reset` deasserted, no downloads → `core_reset` stays 1 indefinitely and `loaded` = 0.
- Index 0 download writing addrs 0..16383 → `loaded` = 0001 and `dl_len` = 16384. `core_reset` falls exactly 1025 cycles after the fall.
- In RUN, index 1 download of 300 bytes → `core_reset` stays 0, `loaded` = 0011, `dl_len` = 300, and `dl_done` is high for one cycle.
- In RUN, `rst_req` high for 5 cycles → `core_reset` is 1 from the next cycle and returns to 0 exactly 1024 cycles after `rst_req` drops.
- Index 7 download of 10 bytes, then an index 0 download with zero writes → `dl_err` pulses once and `dl_len` = 10. `loaded` stays 0000, the FSM returns to WAIT, and `dl_len` = 0.
- `reset` asserted mid index-0 download, then released before the fall → no `dl_done`, `loaded` = 0, `core_reset` = 1.
